// File: rtl/wb_reg_pkg.sv
// wb_reg_pkg: shared write-mode and handshake-state types for the register bank
package wb_reg_pkg;
    typedef enum logic [1:0] {
        WB_REG_WRITE,
        WB_REG_SET,
        WB_REG_CLEAR,
        WB_REG_TOGGLE
    } wb_reg_mode_t;
    typedef enum logic {
        WB_IDLE,
        WB_RESP
    } wb_reg_state_t;
endpackage

// File: rtl/wb_reg_bank_if.sv
// wishbone_b3: classic-cycle Wishbone B3 bus bundle with master/slave views
interface wishbone_b3 #(
    parameter int DATA_WIDTH   = 32,
    parameter int SELECT_WIDTH = 4,
    parameter int ADR_WIDTH    = 32
);
    logic                    cyc;
    logic                    stb;
    logic                    we;
    logic [ADR_WIDTH-1:0]    adr;
    logic [SELECT_WIDTH-1:0] sel;
    logic [DATA_WIDTH-1:0]   dat_m2s;
    logic [DATA_WIDTH-1:0]   dat_s2m;
    logic                    ack;
    logic                    err;
    logic                    rty;
    modport master (output cyc, stb, we, adr, sel, dat_m2s, input dat_s2m, ack, err, rty);
    modport slave  (input cyc, stb, we, adr, sel, dat_m2s, output dat_s2m, ack, err, rty);
endinterface

// File: rtl/wb_reg_merge.sv
// wb_reg_merge: per-granule overwrite/set/clear/toggle of one register word
module wb_reg_merge
    import wb_reg_pkg::*;
#(
    parameter int DATA_WIDTH   = 32,
    parameter int SELECT_WIDTH = 4
) (
    input  logic [DATA_WIDTH-1:0]   old_i,
    input  logic [DATA_WIDTH-1:0]   data_i,
    input  logic [SELECT_WIDTH-1:0] sel_i,
    input  wb_reg_mode_t            mode_i,
    output logic [DATA_WIDTH-1:0]   new_o
);
    localparam int GW = DATA_WIDTH / SELECT_WIDTH;
    for (genvar g = 0; g < SELECT_WIDTH; g++) begin : gran
        logic [GW-1:0] o, d, m;
        assign o = old_i[g*GW +: GW];
        assign d = data_i[g*GW +: GW];
        assign m = mode_i == WB_REG_SET    ? o | d  :
                   mode_i == WB_REG_CLEAR  ? o & ~d :
                   mode_i == WB_REG_TOGGLE ? o ^ d  : d;
        assign new_o[g*GW +: GW] = sel_i[g] ? m : o;
    end
endmodule

// File: rtl/wb_reg_bank.sv
// wb_reg_bank: Wishbone B3 register bank with write modes, byte lanes and self-clearing bits
module wb_reg_bank
    import wb_reg_pkg::*;
#(
    parameter int                    DATA_WIDTH   = 32,
    parameter int                    SELECT_WIDTH = 4,
    parameter int                    NUM_REGS     = 4,
    parameter logic [DATA_WIDTH-1:0] RESET_PAT    = '0,
    parameter logic [DATA_WIDTH-1:0] AUTOCLR_MASK = '0
) (
    input  logic                                clk,
    input  logic                                reset_n,
    wishbone_b3.slave                           bus,
    output logic [NUM_REGS-1:0][DATA_WIDTH-1:0] out,
    output logic [NUM_REGS-1:0]                 changed
);
    localparam int SELECT_BITS = $clog2(SELECT_WIDTH);
    localparam int IDX_W = NUM_REGS > 1 ? $clog2(NUM_REGS) : 1;
    localparam logic [DATA_WIDTH-1:0] KEEP = ~AUTOCLR_MASK;

    wb_reg_state_t                       state_q, state_d;
    logic [NUM_REGS-1:0][DATA_WIDTH-1:0] regs_q, regs_d;
    logic [NUM_REGS-1:0]                 changed_q, changed_d;
    logic                                ack_q, ack_d, err_q, err_d;
    logic [DATA_WIDTH-1:0]               dat_q, dat_d, old, merged;
    logic [IDX_W-1:0]                    idx;
    logic                                in_range, accept, wr;
    wb_reg_mode_t                        mode;

    assign idx      = NUM_REGS > 1 ? bus.adr[SELECT_BITS+2 +: IDX_W] : '0;
    assign mode     = wb_reg_mode_t'(bus.adr[SELECT_BITS +: 2]);
    assign in_range = int'(idx) < NUM_REGS;
    assign old      = in_range ? regs_q[idx] : '0;

    // Self-clearing bits always merge from 0 so a pulse never survives a second edge
    wb_reg_merge #(.DATA_WIDTH(DATA_WIDTH), .SELECT_WIDTH(SELECT_WIDTH)) u_merge (
        .old_i  (old & KEEP),
        .data_i (bus.dat_m2s),
        .sel_i  (bus.sel),
        .mode_i (mode),
        .new_o  (merged)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state_q <= WB_IDLE;
        else          state_q <= state_d;
    end

    always_comb begin
        accept    = state_q == WB_IDLE && bus.cyc && bus.stb;
        wr        = accept && bus.we && in_range;
        state_d   = accept ? WB_RESP : WB_IDLE;
        ack_d     = accept && in_range;
        err_d     = accept && !in_range;
        dat_d     = accept ? old : dat_q;
        regs_d    = regs_q;
        changed_d = '0;
        for (int i = 0; i < NUM_REGS; i++) begin
            regs_d[i]    = (wr && int'(idx) == i) ? merged : regs_q[i] & KEEP;
            changed_d[i] = regs_d[i] != regs_q[i];
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            regs_q    <= {NUM_REGS{RESET_PAT & KEEP}};
            changed_q <= '0;
            ack_q     <= 1'b0;
            err_q     <= 1'b0;
            dat_q     <= '0;
        end else begin
            regs_q    <= regs_d;
            changed_q <= changed_d;
            ack_q     <= ack_d;
            err_q     <= err_d;
            dat_q     <= dat_d;
        end
    end

    assign bus.dat_s2m = dat_q;
    assign bus.ack     = ack_q;
    assign bus.err     = err_q;
    assign bus.rty     = 1'b0;
    assign out         = regs_q;
    assign changed     = changed_q;
endmodule

// File: tb/tb_wb_reg_bank.sv
// tb_wb_reg_bank: directed checks of modes, byte lanes, range errors, autoclear and reset abort
module tb_wb_reg_bank;
  import wb_reg_pkg::*;
  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;
  wishbone_b3 #(.ADR_WIDTH(8)) bus0 ();
  wishbone_b3 #(.ADR_WIDTH(8)) bus1 ();
  logic [2:0][31:0] out0, out1;
  logic [2:0] ch0, ch1;
  wb_reg_bank #(.NUM_REGS(3)) dut0 (
    .clk(clk), .reset_n(reset_n), .bus(bus0), .out(out0), .changed(ch0)
  );
  wb_reg_bank #(.NUM_REGS(3), .RESET_PAT(32'hA5A5_0000), .AUTOCLR_MASK(32'h1)) dut1 (
    .clk(clk), .reset_n(reset_n), .bus(bus1), .out(out1), .changed(ch1)
  );
  typedef struct {
    logic ack, err, rty;
    logic [31:0] dat;
    logic [2:0][31:0] o;
    logic [2:0] ch;
  } snap_t;
  int total = 0;
  int bad = 0;
  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask
  function automatic snap_t snap(input int d);
    snap_t s;
    if (d == 0) begin
      s.ack = bus0.ack; s.err = bus0.err; s.rty = bus0.rty; s.dat = bus0.dat_s2m; s.o = out0; s.ch = ch0;
    end else begin
      s.ack = bus1.ack; s.err = bus1.err; s.rty = bus1.rty; s.dat = bus1.dat_s2m; s.o = out1; s.ch = ch1;
    end
    return s;
  endfunction
  task automatic drive(input int d, input bit cyc, input bit we, input int idx, input int mode,
                       input logic [3:0] sel, input logic [31:0] data);
    logic [7:0] a;
    a = 8'((idx << 4) | (mode << 2));
    if (d == 0) begin
      bus0.cyc = cyc; bus0.stb = cyc; bus0.we = we; bus0.adr = a; bus0.sel = sel; bus0.dat_m2s = data;
    end else begin
      bus1.cyc = cyc; bus1.stb = cyc; bus1.we = we; bus1.adr = a; bus1.sel = sel; bus1.dat_m2s = data;
    end
  endtask
  task automatic access(input int d, input bit we, input int idx, input int mode, input logic [3:0] sel,
                        input logic [31:0] data, output snap_t s1, output snap_t s2);
    drive(d, 1'b1, we, idx, mode, sel, data);
    @(negedge clk);
    s1 = snap(d);
    drive(d, 1'b0, 1'b0, 0, 0, 4'h0, 32'h0);
    @(negedge clk);
    s2 = snap(d);
  endtask
  initial begin
    snap_t s1, s2;
    logic [31:0] sweep_d [4];
    logic [31:0] sweep_e [4];
    sweep_d = '{32'h0000_FFFF, 32'h00FF_0000, 32'h0000_000F, 32'hFFFF_FFFF};
    sweep_e = '{32'h0000_FFFF, 32'h00FF_FFFF, 32'h00FF_FFF0, 32'hFF00_000F};
    drive(0, 1'b0, 1'b0, 0, 0, 4'h0, 32'h0);
    drive(1, 1'b0, 1'b0, 0, 0, 4'h0, 32'h0);
    repeat (2) @(negedge clk);
    s1 = snap(0);
    s2 = snap(1);
    chk("rst_out0", s1.o, {3{32'h0}});
    chk("rst_out1", s2.o, {3{32'hA5A5_0000}});
    chk("rst_ack", {s1.ack, s2.ack, s1.err, s2.err}, 4'b0000);
    chk("rst_dat", s2.dat, 32'h0);
    chk("rst_chg", {s1.ch, s2.ch}, 6'b0);
    reset_n = 1'b1;
    for (int k = 0; k < 4; k++) begin
      access(0, 1'b1, 2, k, 4'hF, sweep_d[k], s1, s2);
      chk("sweep_ack", {s1.ack, s1.err}, 2'b10);
      chk("sweep_ack_once", s2.ack, 1'b0);
      access(0, 1'b0, 2, 3 - k, 4'hF, 32'hFFFF_FFFF, s1, s2);
      chk("sweep_rd", s1.dat, sweep_e[k]);
      chk("sweep_rd_hold", s1.o[2], sweep_e[k]);
    end
    chk("rty_zero", s1.rty, 1'b0);
    access(0, 1'b1, 1, 0, 4'b0101, 32'h1122_3344, s1, s2);
    chk("bsel_val", s1.o[1], 32'h0022_0044);
    chk("bsel_chg", s1.ch, 3'b010);
    chk("bsel_chg_once", s2.ch, 3'b000);
    access(0, 1'b1, 1, 0, 4'b0101, 32'h1122_3344, s1, s2);
    chk("same_no_chg", s1.ch, 3'b000);
    access(0, 1'b1, 3, 0, 4'hF, 32'hDEAD_BEEF, s1, s2);
    chk("oor_wr_resp", {s1.ack, s1.err}, 2'b01);
    chk("oor_wr_err_once", s2.err, 1'b0);
    chk("oor_wr_regs", s1.o, {32'hFF00_000F, 32'h0022_0044, 32'h0});
    chk("oor_wr_chg", s1.ch, 3'b000);
    access(0, 1'b0, 2, 0, 4'hF, 32'h0, s1, s2);
    chk("rd_reg2", s1.dat, 32'hFF00_000F);
    access(0, 1'b0, 3, 0, 4'hF, 32'h0, s1, s2);
    chk("oor_rd_resp", {s1.ack, s1.err}, 2'b01);
    chk("oor_rd_dat", s1.dat, 32'h0);
    access(1, 1'b1, 0, 1, 4'hF, 32'h1, s1, s2);
    chk("ac_set", s1.o[0], 32'hA5A5_0001);
    chk("ac_set_chg", s1.ch, 3'b001);
    chk("ac_clr", s2.o[0], 32'hA5A5_0000);
    chk("ac_clr_chg", s2.ch, 3'b001);
    @(negedge clk);
    s1 = snap(1);
    chk("ac_quiet", {s1.ch, s1.o[0]}, {3'b000, 32'hA5A5_0000});
    drive(1, 1'b1, 1'b1, 1, 0, 4'hF, 32'h1234_5678);
    #2 reset_n = 1'b0;
    @(negedge clk);
    s1 = snap(1);
    chk("rst_abort_resp", {s1.ack, s1.err}, 2'b00);
    chk("rst_abort_reg", s1.o[1], 32'hA5A5_0000);
    @(negedge clk);
    reset_n = 1'b1;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      s1 = snap(1);
      chk("b2b_ack", s1.ack, (k % 2 == 0) ? 1'b1 : 1'b0);
    end
    chk("b2b_reg", s1.o[1], 32'h1234_5678);
    drive(1, 1'b0, 1'b0, 0, 0, 4'h0, 32'h0);
    @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/wb_reg_bank.md
WB_REG_BANK -- requirements
Module: wb_reg_bank

Interface
REQ-001 Parameter DATA_WIDTH, default 32, width of each register and of the bus data.
REQ-002 Parameter SELECT_WIDTH, default 4, number of byte-select lanes; granule = DATA_WIDTH/SELECT_WIDTH.
REQ-003 Parameter NUM_REGS, default 4, number of registers in the bank (1..16).
REQ-004 Parameter RESET_PAT, default 0, DATA_WIDTH-bit reset value loaded into every register.
REQ-005 Parameter AUTOCLR_MASK, default 0, DATA_WIDTH-bit mask of self-clearing (pulse) bits, common to all registers.
REQ-006 Port clk  input  1  sole clock; all state changes on its rising edge.
REQ-007 Port reset_n  input  1  asynchronous, active-low reset.
REQ-008 Port bus  wishbone_b3.slave  interface  classic-cycle Wishbone B3 slave (cyc, stb, we, adr, sel, dat_m2s, dat_s2m, ack, err, rty).
REQ-009 Port out  output  NUM_REGS x DATA_WIDTH  current contents of every register.
REQ-010 Port changed  output  NUM_REGS  one-cycle pulse per register whose value changed on the previous edge.

Function
REQ-011 Address decode: mode = adr[SELECT_BITS+1:SELECT_BITS]; index = adr[SELECT_BITS+2 +: clog2(NUM_REGS)], with SELECT_BITS = clog2(SELECT_WIDTH).
REQ-012 Write modes per selected granule: 0 overwrite; 1 set (old | data); 2 clear (old & ~data); 3 toggle (old ^ data); unselected granules unchanged.
REQ-013 Index >= NUM_REGS (non-power-of-two bank) is out of range: no register changes, response is err, not ack.
REQ-014 Two-state handshake FSM: IDLE, RESP.
REQ-015 IDLE -> RESP on the edge where cyc & stb is sampled high; write commits and read data latches on that same edge.
REQ-016 In RESP, exactly one of ack/err is high for exactly one cycle; RESP -> IDLE unconditionally on the next edge.
REQ-017 Consequently each access takes 2 cycles; a master holding stb gets a new access accepted in the cycle after RESP.
REQ-018 If cyc drops while in RESP, the FSM still returns to IDLE and the already-committed write stands.
REQ-019 rty is constant 0.
REQ-020 Read data (dat_s2m) is the addressed register value captured at acceptance, held stable while in RESP, 0 on out-of-range reads; the mode field is ignored on reads.
REQ-021 AUTOCLR_MASK bits: a write that sets such a bit leaves it at 1 for exactly one cycle, then it clears to 0 on the next edge regardless of bus activity; reads in RESP return the captured 1.
REQ-022 Any other bit changes only through an accepted write.
REQ-023 changed[i] is high during the cycle after any edge where out[i] took a new value, including autoclear transitions; a write of identical data does not pulse.
REQ-024 ack, err and changed are registered outputs; out is driven directly from the register flops.

Reset
REQ-025 While reset_n is low: every register = RESET_PAT & ~AUTOCLR_MASK, FSM = IDLE, ack = err = 0, changed = 0, dat_s2m = 0.
REQ-026 Reset asserted mid-access aborts it: no ack/err is issued for that access, and any write not yet committed is discarded.
REQ-027 First access is accepted on the first rising edge after reset_n deasserts.

Structure
REQ-028 Shared package wb_reg_pkg holds the mode enum wb_reg_mode_t (WB_REG_WRITE, WB_REG_SET, WB_REG_CLEAR, WB_REG_TOGGLE) and the FSM state typedef.
REQ-029 One sub-module, wb_reg_merge, computes the per-granule next value from old value, data, sel and mode (combinational); it is instantiated once, on the addressed register.

Verification
REQ-030 Reset pattern: RESET_PAT=32'hA5A5_0000, AUTOCLR_MASK=1 -> after reset all out = A5A5_0000, ack = err = 0.
REQ-031 Mode sweep on reg 2: write 0x0000_FFFF in mode 0, 0x00FF_0000 in mode 1, 0x0000_000F in mode 2, 0xFFFF_FFFF in mode 3 -> reads 0000_FFFF, 00FF_FFFF, 00FF_FFF0, FF00_000F; each access is acked exactly 1 cycle after acceptance.
REQ-032 Byte select: reg 1 = 0, write 0x1122_3344 in mode 0 with sel=4'b0101 -> reg 1 = 0x0022_0044; changed[1] pulses once, other changed bits stay low.
REQ-033 Out of range with NUM_REGS=3: write to index 3 -> err for 1 cycle, ack low, all registers unchanged; read of index 3 returns 0 with err.
REQ-034 Autoclear: AUTOCLR_MASK=1, set-mode write of 0x1 -> bit0 high for exactly one cycle then 0; changed pulses on both transitions.
REQ-035 Reset mid-access: drop reset_n on the acceptance cycle of a mode-0 write -> no ack, register = reset value; after release, back-to-back accesses with stb held complete every 2 cycles.
